// File: rtl/ap_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : ap_ctrl_watchdog
// Brief    : ap_ctrl_hs run sequencer for the merger tree core with
//            watchdog-timeout abort, elapsed-cycle counter and timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module ap_ctrl_watchdog #(
    parameter int CNT_W        = 32,
    parameter int ABORT_CYCLES = 16
) (
    input  logic             aclk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             core_start,
    input  logic             core_done,
    input  logic             time_out,
    output logic             core_abort,
    output logic [CNT_W-1:0] elapsed,
    output logic             timed_out
);

    localparam int                c_AB_W        = $clog2(ABORT_CYCLES + 1);
    localparam logic [c_AB_W-1:0] c_AB_LOAD     = c_AB_W'(ABORT_CYCLES);
    localparam logic [c_AB_W-1:0] c_AB_LAST     = c_AB_W'(1);
    localparam logic [CNT_W-1:0]  c_ELAPSED_MAX = '1;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_RUN   = 5'b00100,
        S_ABORT = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_AB_W-1:0]   r_abort_cnt;
    logic [CNT_W-1:0]    r_elapsed;
    logic                r_timed_out;

    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // core_done has priority over time_out when both land in the same RUN cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_state_nxt = S_START;
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                if (core_done) begin
                    w_state_nxt = S_DONE;
                end else if (time_out) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: if (r_abort_cnt == c_AB_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_elapsed   <= '0;
            r_timed_out <= 1'b0;
            r_abort_cnt <= '0;
        end else begin
            case (r_state)
                S_START: begin
                    r_elapsed   <= '0;
                    r_timed_out <= 1'b0;
                end
                S_RUN: begin
                    if (r_elapsed != c_ELAPSED_MAX) begin
                        r_elapsed <= r_elapsed + CNT_W'(1);
                    end
                    if (!core_done && time_out) begin
                        r_timed_out <= 1'b1;
                        r_abort_cnt <= c_AB_LOAD;
                    end
                end
                S_ABORT: r_abort_cnt <= r_abort_cnt - c_AB_W'(1);
                default: ;
            endcase
        end
    end

    assign ap_idle    = (r_state == S_IDLE);
    assign ap_ready   = (r_state == S_START);
    assign core_start = (r_state == S_START);
    assign core_abort = (r_state == S_ABORT);
    assign ap_done    = (r_state == S_DONE);
    assign elapsed    = r_elapsed;
    assign timed_out  = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_ctrl_watchdog
// Brief    : Scoreboard bench for ap_ctrl_watchdog (32-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_watchdog;

    localparam int c_ABORT = 16;

    logic        aclk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        core_done;
    logic        time_out;
    logic        ap_ready, ap_done, ap_idle, core_start, core_abort, timed_out;
    logic [31:0] elapsed;
    logic        s_ap_ready, s_ap_done, s_ap_idle, s_core_start, s_core_abort, s_timed_out;
    logic [3:0]  s_elapsed;

    ap_ctrl_watchdog #(.CNT_W(32), .ABORT_CYCLES(c_ABORT)) dut (
        .aclk(aclk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_idle(ap_idle), .core_start(core_start),
        .core_done(core_done), .time_out(time_out), .core_abort(core_abort),
        .elapsed(elapsed), .timed_out(timed_out)
    );

    ap_ctrl_watchdog #(.CNT_W(4), .ABORT_CYCLES(c_ABORT)) dut_sat (
        .aclk(aclk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(s_ap_ready),
        .ap_done(s_ap_done), .ap_idle(s_ap_idle), .core_start(s_core_start),
        .core_done(core_done), .time_out(time_out), .core_abort(s_core_abort),
        .elapsed(s_elapsed), .timed_out(s_timed_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int unsigned el;
        int unsigned el4;
        bit          to;
        int unsigned ab;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_push   = 0;
    int unsigned n_done   = 0;
    int unsigned tot_starts = 0;
    int unsigned mon_starts = 0;
    int unsigned mon_ready  = 0;
    int unsigned mon_abort  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_exp(input int unsigned n, input bit to, input int unsigned ab);
        exp_t e;
        e.el  = n;
        e.el4 = (n > 15) ? 15 : n;
        e.to  = to;
        e.ab  = ab;
        sb_q.push_back(e);
        n_push++;
    endtask

    // End-of-run monitor: each ap_done pops one expected result
    always @(posedge aclk) begin
        exp_t e;
        #1;
        if (!ap_rst_n) begin
            mon_starts = 0;
            mon_ready  = 0;
            mon_abort  = 0;
        end else begin
            if (core_start) begin
                mon_starts++;
                tot_starts++;
            end
            if (ap_ready)   mon_ready++;
            if (core_abort) mon_abort++;
            if (ap_done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("elapsed",   elapsed,           e.el);
                    chk("elapsed4",  {28'd0, s_elapsed}, e.el4);
                    chk("sat_done",  {31'd0, s_ap_done}, 32'd1);
                    chk("timed_out", {31'd0, timed_out}, {31'd0, e.to});
                    chk("abort_len", mon_abort,          e.ab);
                    chk("starts",    mon_starts,         32'd1);
                    chk("readys",    mon_ready,          32'd1);
                end
                mon_starts = 0;
                mon_ready  = 0;
                mon_abort  = 0;
            end
        end
    end

    // n RUN cycles; event on the n-th. mode 0: core_done, 1: time_out, 2: both
    task automatic do_run(input int unsigned n, input int mode, input bit inject);
        bit to_wins;
        to_wins  = (mode == 1);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        chk("start_pulse", {31'd0, core_start}, 32'd1);
        chk("start_idle",  {31'd0, ap_idle},    32'd0);
        tick();
        for (int i = 1; i < int'(n); i++) tick();
        core_done = (mode != 1);
        time_out  = (mode != 0);
        push_exp(n, to_wins, to_wins ? c_ABORT : 0);
        tick();
        core_done = 1'b0;
        time_out  = 1'b0;
        if (to_wins) begin
            chk("abort_first", {31'd0, core_abort}, 32'd1);
            for (int i = 1; i < c_ABORT; i++) begin
                if (inject && i == 5) core_done = 1'b1;
                tick();
                core_done = 1'b0;
            end
            tick();
            chk("abort_end", {31'd0, core_abort}, 32'd0);
        end
        chk("done_lat", {31'd0, ap_done}, 32'd1);
        tick();
        chk("idle_lat", {31'd0, ap_idle}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

    initial begin
        ap_rst_n  = 1'b0;
        ap_start  = 1'b0;
        core_done = 1'b0;
        time_out  = 1'b0;
        repeat (3) tick();
        chk("rst_idle",    {31'd0, ap_idle},    32'd1);
        chk("rst_ready",   {31'd0, ap_ready},   32'd0);
        chk("rst_done",    {31'd0, ap_done},    32'd0);
        chk("rst_start",   {31'd0, core_start}, 32'd0);
        chk("rst_abort",   {31'd0, core_abort}, 32'd0);
        chk("rst_to",      {31'd0, timed_out},  32'd0);
        chk("rst_elapsed", elapsed,             32'd0);
        ap_rst_n = 1'b1;
        repeat (10) tick();
        #2;
        chk("no_start", tot_starts, 32'd0);
        chk("idle_hold", {31'd0, ap_idle}, 32'd1);

        do_run(100, 0, 1'b0);
        do_run(50, 1, 1'b1);
        do_run(7, 2, 1'b0);
        do_run(1, 0, 1'b0);
        do_run(20, 0, 1'b0);

        // Stale pulses in IDLE
        core_done = 1'b1;
        time_out  = 1'b1;
        tick();
        core_done = 1'b0;
        time_out  = 1'b0;
        tick();
        chk("stale_idle",    {31'd0, ap_idle},   32'd1);
        chk("stale_elapsed", elapsed,            32'd20);
        chk("stale_to",      {31'd0, timed_out}, 32'd0);

        // Back-to-back with ap_start held high
        ap_start = 1'b1;
        tick();
        chk("b2b_start1", {31'd0, core_start}, 32'd1);
        tick();
        chk("b2b_clr1", elapsed, 32'd0);
        repeat (4) tick();
        core_done = 1'b1;
        push_exp(5, 1'b0, 0);
        tick();
        core_done = 1'b0;
        chk("b2b_done1", {31'd0, ap_done}, 32'd1);
        tick();
        chk("b2b_idle", {31'd0, ap_idle}, 32'd1);
        tick();
        chk("b2b_start2", {31'd0, core_start}, 32'd1);
        chk("b2b_hold",   elapsed,             32'd5);
        ap_start = 1'b0;
        tick();
        chk("b2b_clr2", elapsed, 32'd0);
        repeat (2) tick();
        core_done = 1'b1;
        push_exp(3, 1'b0, 0);
        tick();
        core_done = 1'b0;
        chk("b2b_done2", {31'd0, ap_done}, 32'd1);
        tick();

        // Reset in the middle of ABORT
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        repeat (9) tick();
        time_out = 1'b1;
        tick();
        time_out = 1'b0;
        repeat (4) tick();
        chk("mid_abort", {31'd0, core_abort}, 32'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("rst_abort_drop", {31'd0, core_abort}, 32'd0);
        chk("rst_abort_idle", {31'd0, ap_idle},    32'd1);
        chk("rst_abort_el",   elapsed,             32'd0);
        repeat (3) tick();
        ap_rst_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_idle", {31'd0, ap_idle}, 32'd1);

        chk("sb_empty",   sb_q.size(), 32'd0);
        chk("done_count", n_done,      n_push);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ap_ctrl_watchdog.md
# ap_ctrl_watchdog

Kernel control sequencer that sits directly upstream of the watchdog timer (`time_cnt`) and the merger tree core. It converts the host `ap_ctrl_hs` start into a single-cycle start pulse for both blocks. It then waits for either core completion or the timer's `time_out` pulse, flushes the core on timeout, and returns `ap_done` to the host. It also reports elapsed run cycles and a timeout flag for the host status registers.

## Interface
- `CNT_W`, 32: width of the elapsed-cycle counter.
- `ABORT_CYCLES`, 16: number of cycles `core_abort` is held high on timeout; legal range ≥1.

- `aclk` input, 1: kernel clock.
- `ap_rst_n` input, 1: reset, asynchronous, active-low.
- `ap_start` input, 1: host start, level.
- `ap_ready` output, 1: one-cycle pulse when the start is accepted.
- `ap_done` output, 1: one-cycle pulse at end of run (normal or timeout).
- `ap_idle` output, 1: high while in IDLE.
- `core_start` output, 1: one-cycle pulse; drives merger tree start and the `time_cnt` `ap_start` input.
- `core_done` input, 1: one-cycle pulse from the merger tree.
- `time_out` input, 1: one-cycle pulse from `time_cnt`.
- `core_abort` output, 1: flush/reset request to the merger tree.
- `elapsed` output, `CNT_W`: number of cycles spent in RUN during the last or current run.
- `timed_out` output, 1: last run ended by timeout.

## Operation
- One-hot registered FSM with states IDLE, START, RUN, ABORT, DONE. All control outputs are decodes of the state register (Moore), so there are no combinational input-to-output paths.
- **IDLE:** `ap_idle`=1. If `ap_start`=1, go to START; otherwise stay.
- **START:** `core_start`=1 and `ap_ready`=1 for exactly this cycle. `elapsed` is cleared to 0 and `timed_out` to 0 at the end of this cycle. Always go to RUN.
- **RUN:**
  - `elapsed` increments by 1 each RUN cycle and saturates at 2^CNT_W−1 (no wrap).
  - If `core_done`=1, go to DONE.
  - Else if `time_out`=1, set `timed_out`=1, load the abort counter with ABORT_CYCLES, and go to ABORT.
  - If both are asserted in the same cycle, `core_done` wins: DONE with `timed_out`=0.
- **ABORT:**
  - `core_abort`=1. The abort counter decrements each cycle. When it reaches 1, go to DONE, so `core_abort` is high for exactly ABORT_CYCLES cycles.
  - `core_done` is ignored in this state.
- **DONE:** `ap_done`=1 for this cycle only. Always go to IDLE.
- `time_out` and `core_done` are ignored in IDLE, START, ABORT and DONE. This discards stale pulses from a previous run.
- `elapsed` and `timed_out` hold their values from the end of a run until the next START.
- `ap_start` is sampled only in IDLE. If the host holds it high continuously, the next run begins on the cycle after DONE+IDLE.

## Timing
- **Reset** (`ap_rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `ap_idle`=1.
  - `ap_ready`, `ap_done`, `core_start`, `core_abort`, `timed_out` = 0.
  - `elapsed`=0.
- **Reset mid-run** (RUN or ABORT): return to IDLE immediately, with no `ap_done` and no further `core_abort` cycles.
- **Start latency:** `ap_start` high in IDLE at edge t gives `core_start`/`ap_ready` high in cycle t+1 and RUN from t+2.
- **Completion latency:** `core_done` in RUN cycle n gives `ap_done` in cycle n+1 and `ap_idle` in cycle n+2.
- **Timeout latency:** `time_out` in RUN cycle n gives `core_abort` in cycles n+1 … n+ABORT_CYCLES, `ap_done` in cycle n+ABORT_CYCLES+1, and `ap_idle` in cycle n+ABORT_CYCLES+2.
- **`elapsed` counting:** counts the cycle in which `core_done`/`time_out` is seen. A `core_done` in the first RUN cycle gives `elapsed`=1.
- **Minimum run-to-run spacing:** 4 cycles (IDLE, START, RUN, DONE).

## Test plan
- **Reset values:** assert `ap_rst_n`=0 for 3 cycles, then release → `ap_idle`=1, all pulses 0, `elapsed`=0, `timed_out`=0. Hold `ap_start`=0 for 10 cycles → no `core_start`.
- **Normal run:** pulse `ap_start`, then `core_done` 100 cycles into RUN → exactly one `core_start` and one `ap_ready` cycle, `ap_done` one cycle later, `elapsed`=100, `timed_out`=0, `core_abort` never high.
- **Timeout run:** ABORT_CYCLES=16, `time_out` pulse at RUN cycle 50 → `core_abort` high exactly 16 cycles, `ap_done` on the 17th cycle, `timed_out`=1, `elapsed`=50. A `core_done` injected during ABORT is ignored.
- **Simultaneous events:** `core_done` and `time_out` in the same RUN cycle → DONE next cycle, `timed_out`=0, no `core_abort`.
- **Stale pulses and back-to-back:** inject `time_out`/`core_done` while IDLE → no state change. Hold `ap_start`=1 across two runs → second `core_start` follows first `ap_done` by exactly 2 cycles, and `elapsed` clears at each START.
- **Reset mid-ABORT and saturation:** assert `ap_rst_n`=0 mid-ABORT → `core_abort` drops asynchronously, no `ap_done`. With CNT_W=4, a run of 20 RUN cycles → `elapsed`=15.
